// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: hazard inputs from ID/EX/MEM and the
// resulting pipeline-register enables, flushes and debug/perf outputs.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_hold;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       state;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_we, ifid_we, ifid_flush, idex_flush, pipe_hold, mem_error,
           stall_cnt, flush_cnt, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    output pc_we, ifid_we, ifid_flush, idex_flush, pipe_hold, mem_error,
           stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Mealy stall/flush/hold decisions from load-use,
// taken branches and data-memory waits, with a wait-timeout FSM and perf counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ACT_NORMAL = 3'd0,
    ACT_BUBBLE = 3'd1,
    ACT_BRANCH = 3'd2,
    ACT_FREEZE = 3'd3,
    ACT_RESET  = 3'd4
  } act_t;

  localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_nxt;
  logic             r_mem_error;
  logic             w_err_set;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  act_t             w_act;
  logic             w_load_use;
  logic             w_mem_stall;
  logic             w_pc_we;
  logic             w_ifid_we;
  logic             w_ifid_flush;
  logic             w_idex_flush;
  logic             w_pipe_hold;

  // Branch outranks load-use: the ID instruction is squashed anyway.
  function automatic act_t resolve_act(input logic branch, input logic load_use);
    act_t act;
    if (branch) begin
      act = ACT_BRANCH;
    end else if (load_use) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_NORMAL;
    end
    return act;
  endfunction

  assign w_load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
  // A dropped mem_req ends the wait just like mem_ready.
  assign w_mem_stall = hz.mem_req && !hz.mem_ready;

  always_comb begin
    w_act       = ACT_FREEZE;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_err_set   = 1'b0;
    if (reset) begin
      w_act       = ACT_RESET;
      w_state_nxt = ST_RUN;
      w_wait_nxt  = 8'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            w_act       = ACT_FREEZE;
            w_state_nxt = ST_MEM_WAIT;
            w_wait_nxt  = 8'd1;
          end else begin
            w_act = resolve_act(hz.ex_branch_taken, w_load_use);
          end
        end
        ST_MEM_WAIT: begin
          if (w_mem_stall) begin
            w_act      = ACT_FREEZE;
            w_wait_nxt = r_wait_cnt + 8'd1;
            if (r_wait_cnt == WAIT_LAST) begin
              w_state_nxt = ST_ERROR;
              w_err_set   = 1'b1;
            end else begin
              w_state_nxt = ST_MEM_WAIT;
            end
          end else begin
            w_act       = resolve_act(hz.ex_branch_taken, w_load_use);
            w_state_nxt = ST_RUN;
            w_wait_nxt  = 8'd0;
          end
        end
        ST_ERROR: begin
          w_act = ACT_FREEZE;
        end
        default: begin
          w_act       = ACT_FREEZE;
          w_state_nxt = ST_ERROR;
          w_err_set   = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_pc_we      = 1'b0;
    w_ifid_we    = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_pipe_hold  = 1'b0;
    case (w_act)
      ACT_RESET: begin
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
      end
      ACT_FREEZE: begin
        w_pipe_hold = 1'b1;
      end
      ACT_BRANCH: begin
        w_pc_we      = 1'b1;
        w_ifid_we    = 1'b1;
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
      end
      ACT_BUBBLE: begin
        w_idex_flush = 1'b1;
      end
      ACT_NORMAL: begin
        w_pc_we   = 1'b1;
        w_ifid_we = 1'b1;
      end
      default: begin
        w_pipe_hold = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= 8'd0;
      r_mem_error <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_err_set) begin
        r_mem_error <= 1'b1;
      end
      if (!w_pc_we && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if ((w_act == ACT_BRANCH) && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign hz.pc_we      = w_pc_we;
  assign hz.ifid_we    = w_ifid_we;
  assign hz.ifid_flush = w_ifid_flush;
  assign hz.idex_flush = w_idex_flush;
  assign hz.pipe_hold  = w_pipe_hold;
  assign hz.mem_error  = r_mem_error;
  assign hz.stall_cnt  = r_stall_cnt;
  assign hz.flush_cnt  = r_flush_cnt;
  assign hz.state      = r_state;

endmodule
